// File: rtl/apb_reg_bank_pkg.sv
// apb_reg_bank_pkg: shared types and constants for the APB register bank.
//   state_t     : transfer FSM state (IDLE, ACCESS).
//   CNT_W       : width of the wait-state counter.
//   evt_off()   : offset of the EVENT register for a given register count.
//   evt_en_off(): offset of the EVENT_EN register for a given register count.
package apb_reg_bank_pkg;

  localparam int CNT_W = 4;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  function automatic int evt_off(input int num_regs);
    return num_regs;
  endfunction

  function automatic int evt_en_off(input int num_regs);
    return num_regs + 1;
  endfunction

endpackage

// File: rtl/apb_reg_bank_if.sv
// apb_reg_bank_if: APB3 bus bundle between a master and the register bank.
//   psel, penable, pwrite, paddr, pwdata : master -> slave
//   prdata, pready                       : slave -> master
//   pslverr                              : slave -> master, only when
//                                          APB_REG_BANK_PSLVERR_EN is defined
interface apb_reg_bank_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [ADDR_W-1:0] paddr;
  logic [DATA_W-1:0] pwdata;
  logic [DATA_W-1:0] prdata;
  logic              pready;
`ifdef APB_REG_BANK_PSLVERR_EN
  logic              pslverr;
`endif

  modport master (
`ifdef APB_REG_BANK_PSLVERR_EN
    input  pslverr,
`endif
    output psel, penable, pwrite, paddr, pwdata,
    input  prdata, pready
  );

  modport slave (
`ifdef APB_REG_BANK_PSLVERR_EN
    output pslverr,
`endif
    input  psel, penable, pwrite, paddr, pwdata,
    output prdata, pready
  );
endinterface

// File: rtl/apb_wait_gen.sv
// apb_wait_gen: APB transfer FSM with programmable wait states.
//   clk, rst    : clock, synchronous active-high reset
//   i_psel      : APB select
//   i_penable   : APB enable
//   o_pready    : high only on the completing access cycle
//   o_done      : one-cycle completion pulse (commit qualifier)
// The first access cycle is evaluated in IDLE with the counter at zero, so
// WAIT_STATES=0 completes immediately and WAIT_STATES=N completes on the
// (N+1)th access cycle.
module apb_wait_gen
  import apb_reg_bank_pkg::*;
#(
  parameter int WAIT_STATES = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic i_psel,
  input  logic i_penable,
  output logic o_pready,
  output logic o_done
);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             w_req;
  logic             w_last;

  assign w_req  = i_psel & i_penable;
  assign w_last = (r_cnt == CNT_W'(WAIT_STATES));

  // Gated by rst so a transfer caught by reset can never complete.
  assign o_pready = ~rst & w_req & w_last;
  assign o_done   = o_pready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_req && !w_last) begin
            r_state <= ACCESS;
            r_cnt   <= r_cnt + 1'b1;
          end
        end
        ACCESS: begin
          // Completion or an abandoned transfer both return to IDLE.
          if (!w_req || w_last) begin
            r_state <= IDLE;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/apb_reg_bank.sv
// apb_reg_bank: parametrised APB3 slave register bank.
//   clk, rst  : clock, synchronous active-high reset
//   apb       : APB slave bus (apb_reg_bank_if.slave)
//   ctrl      : control bits, register i at [i*DATA_W +: DATA_W]
//   stat      : status inputs, same packing (only ~CTRL_MASK bits used)
//   wr_strobe : one-cycle pulse per register on a completed write
//   rd_strobe : one-cycle pulse per register on a completed read
//   evt_in    : level event inputs, sampled every cycle into EVENT
//   irq       : registered OR of EVENT & EVENT_EN
// Map (offset from BASE_ADDR): 0..NUM_REGS-1 ctrl/stat, NUM_REGS EVENT (W1C),
// NUM_REGS+1 EVENT_EN, everything else unmapped.
// Optional macro APB_REG_BANK_PSLVERR_EN adds pslverr on unmapped accesses.
module apb_reg_bank
  import apb_reg_bank_pkg::*;
#(
  parameter int                DATA_W      = 8,
  parameter int                ADDR_W      = 8,
  parameter int                NUM_REGS    = 4,
  parameter int                BASE_ADDR   = 0,
  parameter logic [DATA_W-1:0] CTRL_MASK   = DATA_W'(8'hF1),
  parameter int                WAIT_STATES = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  apb_reg_bank_if.slave              apb,
  output logic [NUM_REGS*DATA_W-1:0] ctrl,
  input  logic [NUM_REGS*DATA_W-1:0] stat,
  output logic [NUM_REGS-1:0]        wr_strobe,
  output logic [NUM_REGS-1:0]        rd_strobe,
  input  logic [DATA_W-1:0]          evt_in,
  output logic                       irq
);

  logic              w_done;
  logic              w_pready;
  logic              w_wr;
  logic              w_rd;
  logic              w_below;
  logic [ADDR_W-1:0] w_off;
  logic              w_is_reg;
  logic              w_is_evt;
  logic              w_is_en;
  logic [DATA_W-1:0] w_evt_clr;
  logic [DATA_W-1:0] w_rdata;

  logic [DATA_W-1:0] r_ctrl [NUM_REGS];
  logic [DATA_W-1:0] r_event;
  logic [DATA_W-1:0] r_event_en;
  logic              r_irq;

  apb_wait_gen #(
    .WAIT_STATES (WAIT_STATES)
  ) u_wait_gen (
    .clk       (clk),
    .rst       (rst),
    .i_psel    (apb.psel),
    .i_penable (apb.penable),
    .o_pready  (w_pready),
    .o_done    (w_done)
  );

  assign apb.pready = w_pready;
  assign w_wr       = w_done & apb.pwrite;
  assign w_rd       = w_done & ~apb.pwrite;

  // Addresses below BASE_ADDR would wrap in the subtraction, so they are
  // excluded explicitly before decoding the offset.
  assign w_below  = (apb.paddr < ADDR_W'(BASE_ADDR));
  assign w_off    = apb.paddr - ADDR_W'(BASE_ADDR);
  assign w_is_reg = !w_below && (w_off < ADDR_W'(NUM_REGS));
  assign w_is_evt = !w_below && (w_off == ADDR_W'(evt_off(NUM_REGS)));
  assign w_is_en  = !w_below && (w_off == ADDR_W'(evt_en_off(NUM_REGS)));

`ifdef APB_REG_BANK_PSLVERR_EN
  logic w_unmapped;
  assign w_unmapped  = ~(w_is_reg | w_is_evt | w_is_en);
  assign apb.pslverr = w_done & w_unmapped;
`endif

  assign w_evt_clr = (w_wr && w_is_evt) ? apb.pwdata : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) r_ctrl[i] <= '0;
      r_event    <= '0;
      r_event_en <= '0;
      r_irq      <= 1'b0;
    end else begin
      // Read-only bit positions are never stored, so they stay zero.
      for (int i = 0; i < NUM_REGS; i++) begin
        if (w_wr && w_is_reg && (w_off == ADDR_W'(i))) r_ctrl[i] <= apb.pwdata & CTRL_MASK;
      end
      // New events win over a same-cycle write-1-to-clear.
      r_event <= (r_event & ~w_evt_clr) | evt_in;
      if (w_wr && w_is_en) r_event_en <= apb.pwdata;
      r_irq <= |(r_event & r_event_en);
    end
  end

  always_comb begin
    w_rdata   = '0;
    wr_strobe = '0;
    rd_strobe = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (w_is_reg && (w_off == ADDR_W'(i))) begin
        wr_strobe[i] = w_wr;
        rd_strobe[i] = w_rd;
        if (w_rd) w_rdata = (r_ctrl[i] & CTRL_MASK) | (stat[i*DATA_W +: DATA_W] & ~CTRL_MASK);
      end
    end
    if (w_rd && w_is_evt) w_rdata = r_event;
    if (w_rd && w_is_en)  w_rdata = r_event_en;
  end

  assign apb.prdata = w_rdata;

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_ctrl
    assign ctrl[g*DATA_W +: DATA_W] = r_ctrl[g] & CTRL_MASK;
  end

  assign irq = r_irq;

endmodule

// File: tb/tb_apb_reg_bank.sv
// tb_apb_reg_bank: directed bench for apb_reg_bank.
// Two instances: u_dut0 with no wait states and u_dut3 with three.
// Default parameters: DATA_W=8, ADDR_W=8, NUM_REGS=4, BASE_ADDR=0, CTRL_MASK=F1.
// pslverr is checked only when APB_REG_BANK_PSLVERR_EN is defined.
module tb_apb_reg_bank;

  logic        clk = 1'b0;
  logic        rst0, rst3;
  logic [31:0] ctrl0, ctrl3, stat0, stat3;
  logic [3:0]  wstb0, rstb0, wstb3, rstb3;
  logic [7:0]  evt0, evt3;
  logic        irq0, irq3;

  int nchk  = 0;
  int nfail = 0;

  apb_reg_bank_if #(.ADDR_W(8), .DATA_W(8)) if0 ();
  apb_reg_bank_if #(.ADDR_W(8), .DATA_W(8)) if3 ();

  apb_reg_bank #(.WAIT_STATES(0)) u_dut0 (
    .clk(clk), .rst(rst0), .apb(if0), .ctrl(ctrl0), .stat(stat0),
    .wr_strobe(wstb0), .rd_strobe(rstb0), .evt_in(evt0), .irq(irq0)
  );

  apb_reg_bank #(.WAIT_STATES(3)) u_dut3 (
    .clk(clk), .rst(rst3), .apb(if3), .ctrl(ctrl3), .stat(stat3),
    .wr_strobe(wstb3), .rd_strobe(rstb3), .evt_in(evt3), .irq(irq3)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit sel3, input logic ps, input logic pe, input logic pw,
                       input logic [7:0] pa, input logic [7:0] pd);
    if (sel3) begin
      if3.psel = ps; if3.penable = pe; if3.pwrite = pw; if3.paddr = pa; if3.pwdata = pd;
    end else begin
      if0.psel = ps; if0.penable = pe; if0.pwrite = pw; if0.paddr = pa; if0.pwdata = pd;
    end
  endtask

  function automatic logic cur_pready(input bit sel3);
    return sel3 ? if3.pready : if0.pready;
  endfunction

  function automatic logic [7:0] cur_prdata(input bit sel3);
    return sel3 ? if3.prdata : if0.prdata;
  endfunction

  function automatic logic [3:0] cur_wstb(input bit sel3);
    return sel3 ? wstb3 : wstb0;
  endfunction

  function automatic logic [3:0] cur_rstb(input bit sel3);
    return sel3 ? rstb3 : rstb0;
  endfunction

  function automatic logic cur_err(input bit sel3);
`ifdef APB_REG_BANK_PSLVERR_EN
    return sel3 ? if3.pslverr : if0.pslverr;
`else
    return sel3 & 1'b0;
`endif
  endfunction

  // One complete APB transfer; 'early' flags any strobe, pready or nonzero
  // prdata seen before the completing cycle.
  task automatic xfer(input bit sel3, input bit wr, input logic [7:0] addr, input logic [7:0] wd,
                      output logic [7:0] rd, output int waits, output logic [3:0] wstb,
                      output logic [3:0] rstb, output logic early, output logic err);
    bit done;
    rd = '0; wstb = '0; rstb = '0; err = 1'b0; waits = 0; done = 1'b0;
    @(negedge clk);
    drive(sel3, 1'b1, 1'b0, wr, addr, wd);
    #1 early = (|cur_wstb(sel3)) | (|cur_rstb(sel3)) | cur_pready(sel3);
    @(negedge clk);
    drive(sel3, 1'b1, 1'b1, wr, addr, wd);
    for (int n = 0; n < 20 && !done; n++) begin
      #1;
      if (cur_pready(sel3)) begin
        rd   = cur_prdata(sel3);
        wstb = cur_wstb(sel3);
        rstb = cur_rstb(sel3);
        err  = cur_err(sel3);
        done = 1'b1;
      end else begin
        early = early | (|cur_wstb(sel3)) | (|cur_rstb(sel3)) | (cur_prdata(sel3) != 8'h00);
        waits++;
        @(negedge clk);
      end
    end
    check("xfer_completes", {31'd0, done}, 32'd1);
    @(negedge clk);
    drive(sel3, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
  endtask

  logic [7:0] rd;
  logic [3:0] ws, rs;
  logic       early, err;
  int         w;

  initial begin
    rst0 = 1'b1; rst3 = 1'b1;
    stat0 = '0; stat3 = '0; evt0 = '0; evt3 = '0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    repeat (3) @(negedge clk);
    rst0 = 1'b0; rst3 = 1'b0;
    #1;
    check("reset_ctrl0", ctrl0, 32'h0);
    check("reset_ctrl3", ctrl3, 32'h0);
    check("reset_irq0", {31'd0, irq0}, 32'd0);
    check("reset_pready0", {31'd0, if0.pready}, 32'd0);

    // Every mapped offset reads zero after reset.
    for (int a = 0; a < 6; a++) begin
      xfer(1'b0, 1'b0, 8'(a), 8'h00, rd, w, ws, rs, early, err);
      check($sformatf("reset_read_off%0d", a), 32'(rd), 32'h0);
      check($sformatf("reset_read_waits%0d", a), 32'(w), 32'd0);
    end
    check("reset_irq_after_reads", {31'd0, irq0}, 32'd0);

    // Write FF to register 1: only CTRL_MASK bits land.
    xfer(1'b0, 1'b1, 8'h01, 8'hFF, rd, w, ws, rs, early, err);
    check("wr1_strobe", 32'(ws), 32'h2);
    check("wr1_no_rstrobe", 32'(rs), 32'h0);
    #1;
    check("wr1_strobe_one_cycle", 32'(wstb0), 32'h0);
    check("wr1_ctrl", ctrl0, 32'h0000_F100);

    // Read-back mixes ctrl bits with status bits.
    stat0 = 32'h0000_0EFF;
    xfer(1'b0, 1'b0, 8'h01, 8'h00, rd, w, ws, rs, early, err);
    check("rd1_data", 32'(rd), 32'hFF);
    check("rd1_strobe", 32'(rs), 32'h2);
    check("rd1_no_wstrobe", 32'(ws), 32'h0);
    xfer(1'b0, 1'b0, 8'h00, 8'h00, rd, w, ws, rs, early, err);
    check("rd0_status_only", 32'(rd), 32'h0E);
    stat0 = '0;

    // Three wait states on the second instance.
    xfer(1'b1, 1'b1, 8'h02, 8'h35, rd, w, ws, rs, early, err);
    check("ws3_wr_waits", 32'(w), 32'd3);
    check("ws3_wr_strobe", 32'(ws), 32'h4);
    check("ws3_wr_no_early", {31'd0, early}, 32'd0);
    #1;
    check("ws3_wr_ctrl", ctrl3, 32'h0031_0000);
    xfer(1'b1, 1'b0, 8'h02, 8'h00, rd, w, ws, rs, early, err);
    check("ws3_rd_waits", 32'(w), 32'd3);
    check("ws3_rd_data", 32'(rd), 32'h31);
    check("ws3_rd_strobe", 32'(rs), 32'h4);
    check("ws3_rd_no_early", {31'd0, early}, 32'd0);

    // Event capture, enable and registered interrupt.
    @(negedge clk); evt0 = 8'h04;
    @(negedge clk); evt0 = 8'h00;
    #1 check("evt_irq_before_en", {31'd0, irq0}, 32'd0);
    xfer(1'b0, 1'b1, 8'h05, 8'h04, rd, w, ws, rs, early, err);
    #1 check("evt_irq_latency", {31'd0, irq0}, 32'd0);
    @(negedge clk);
    #1 check("evt_irq_set", {31'd0, irq0}, 32'd1);
    xfer(1'b0, 1'b0, 8'h04, 8'h00, rd, w, ws, rs, early, err);
    check("evt_read", 32'(rd), 32'h04);
    xfer(1'b0, 1'b0, 8'h05, 8'h00, rd, w, ws, rs, early, err);
    check("evt_en_read", 32'(rd), 32'h04);

    // A new event beats a same-cycle clear.
    evt0 = 8'h04;
    xfer(1'b0, 1'b1, 8'h04, 8'h04, rd, w, ws, rs, early, err);
    evt0 = 8'h00;
    xfer(1'b0, 1'b0, 8'h04, 8'h00, rd, w, ws, rs, early, err);
    check("evt_set_priority", 32'(rd), 32'h04);
    #1 check("evt_irq_still_set", {31'd0, irq0}, 32'd1);

    // Clear with no incoming event; irq drops one cycle after EVENT.
    xfer(1'b0, 1'b1, 8'h04, 8'h04, rd, w, ws, rs, early, err);
    #1 check("evt_irq_lag", {31'd0, irq0}, 32'd1);
    @(negedge clk);
    #1 check("evt_irq_cleared", {31'd0, irq0}, 32'd0);
    xfer(1'b0, 1'b0, 8'h04, 8'h00, rd, w, ws, rs, early, err);
    check("evt_cleared_read", 32'(rd), 32'h00);

    // Unmapped write and reads.
    xfer(1'b0, 1'b1, 8'h06, 8'hAA, rd, w, ws, rs, early, err);
    check("unmapped_wr_strobe", 32'(ws), 32'h0);
`ifdef APB_REG_BANK_PSLVERR_EN
    check("unmapped_wr_pslverr", {31'd0, err}, 32'd1);
`endif
    #1 check("unmapped_ctrl_kept", ctrl0, 32'h0000_F100);
    xfer(1'b0, 1'b0, 8'h05, 8'h00, rd, w, ws, rs, early, err);
    check("unmapped_en_kept", 32'(rd), 32'h04);
`ifdef APB_REG_BANK_PSLVERR_EN
    check("mapped_no_pslverr", {31'd0, err}, 32'd0);
`endif
    xfer(1'b0, 1'b0, 8'h06, 8'h00, rd, w, ws, rs, early, err);
    check("unmapped_rd_zero", 32'(rd), 32'h00);
    check("unmapped_rd_strobe", 32'(rs), 32'h0);
    xfer(1'b0, 1'b0, 8'hFF, 8'h00, rd, w, ws, rs, early, err);
    check("unmapped_rd_ff_zero", 32'(rd), 32'h00);

    // Reset in the middle of a wait-stated write aborts it.
    @(negedge clk); drive(1'b1, 1'b1, 1'b0, 1'b1, 8'h03, 8'hFF);
    @(negedge clk); drive(1'b1, 1'b1, 1'b1, 1'b1, 8'h03, 8'hFF);
    #1 check("rstmid_pready_c0", {31'd0, if3.pready}, 32'd0);
    @(negedge clk);
    #1 check("rstmid_pready_c1", {31'd0, if3.pready}, 32'd0);
    @(negedge clk); rst3 = 1'b1;
    #1 check("rstmid_pready_rst", {31'd0, if3.pready}, 32'd0);
    early = 1'b0;
    repeat (3) begin
      @(negedge clk);
      #1 early = early | if3.pready | (|wstb3);
    end
    check("rstmid_no_complete", {31'd0, early}, 32'd0);
    @(negedge clk);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    rst3 = 1'b0;
    #1 check("rstmid_ctrl", ctrl3, 32'h0);
    xfer(1'b1, 1'b1, 8'h03, 8'hFF, rd, w, ws, rs, early, err);
    check("rstmid_restart_waits", 32'(w), 32'd3);
    check("rstmid_restart_strobe", 32'(ws), 32'h8);
    #1 check("rstmid_restart_ctrl", ctrl3, 32'hF100_0000);

    // psel dropped mid-access: nothing commits, counter restarts.
    @(negedge clk); drive(1'b1, 1'b1, 1'b0, 1'b1, 8'h00, 8'h55);
    @(negedge clk); drive(1'b1, 1'b1, 1'b1, 1'b1, 8'h00, 8'h55);
    #1 early = if3.pready | (|wstb3);
    repeat (2) begin
      @(negedge clk);
      #1 early = early | if3.pready | (|wstb3);
    end
    @(negedge clk); drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    #1 early = early | if3.pready | (|wstb3);
    check("drop_no_strobe", {31'd0, early}, 32'd0);
    check("drop_ctrl", ctrl3, 32'hF100_0000);
    xfer(1'b1, 1'b0, 8'h00, 8'h00, rd, w, ws, rs, early, err);
    check("drop_next_waits", 32'(w), 32'd3);
    check("drop_next_data", 32'(rd), 32'h00);
    check("drop_next_rstrobe", 32'(rs), 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule
